// File: rtl/upower_fetch_pkg.sv
// ---------------------------------------------------------------------------
// upower_fetch_pkg
// Shared types and constants for the uPower instruction fetch sequencer.
//   fetch_state_t : fetch controller FSM encoding
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   align_word()  : clears the byte-offset bits of a byte address
// ---------------------------------------------------------------------------
package upower_fetch_pkg;

  localparam int INSTR_W         = 32;
  localparam int PC_W            = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;
  localparam int FETCH_BUF_DEPTH = 2;
  // Enough bits to hold an occupancy of 0..FETCH_BUF_DEPTH.
  localparam int BUF_CNT_W       = $clog2(FETCH_BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// ---------------------------------------------------------------------------
// fetch_skid_fifo
// Two-entry FIFO of {pc, instr} pairs that absorbs the instruction memory's
// one-cycle read latency. Push and pop may happen in the same cycle; flush
// empties the FIFO and wins over a simultaneous push.
//   clk, rst_n  : clock, asynchronous active-low reset (pointers/count only)
//   flush       : discard all entries
//   push        : write push_data (ignored when full and not popping)
//   push_data   : entry to write
//   pop         : remove head entry (ignored when empty)
//   head        : oldest entry, meaningful only when !empty
//   count       : current occupancy 0..FETCH_BUF_DEPTH
//   empty       : no entries held
// ---------------------------------------------------------------------------
module fetch_skid_fifo
  import upower_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 push,
  input  fetch_entry_t         push_data,
  input  logic                 pop,
  output fetch_entry_t         head,
  output logic [BUF_CNT_W-1:0] count,
  output logic                 empty
);

  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [BUF_CNT_W-1:0] count_q, count_d;
  fetch_entry_t         slot_q [FETCH_BUF_DEPTH];
  fetch_entry_t         slot_d [FETCH_BUF_DEPTH];

  logic full;
  logic do_push;
  logic do_pop;

  assign full    = (count_q == BUF_CNT_W'(FETCH_BUF_DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    slot_d   = slot_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        slot_d[wr_ptr_q] = push_data;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + BUF_CNT_W'(do_push) - BUF_CNT_W'(do_pop);
    end
  end

  // control state: pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // data storage: only read while count says it is valid, so no reset
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign head  = slot_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
// Fetch sequencer for the uPower instruction memory (synchronous-read word
// array). Owns the PC, issues reads under a credit scheme that covers the
// in-flight read, buffers responses in fetch_skid_fifo and hands them to
// decode over valid/ready. Branch redirects flush the buffer and squash the
// in-flight response via an epoch bit.
//
// Optional build macro FETCH_STALL_CNT_EN adds stall_cycles, a saturating
// count of cycles with instr_valid && !instr_ready (cleared on reset/start).
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin fetching at RESET_PC (IDLE only)
//   mem_rd_en       : read strobe to instruction memory
//   mem_addr        : word address pc[ADDR_W+1:2]
//   mem_rdata       : read data, valid the cycle after mem_rd_en
//   redirect_valid  : branch taken, flush and refetch from redirect_pc
//   redirect_pc     : branch target byte address
//   instr_valid     : instr/instr_pc valid to decode
//   instr_ready     : decode accepts
//   instr, instr_pc : instruction word and its byte PC
//   busy            : state is FETCH or DRAIN
//   done            : state is DONE
//   stall_cycles    : (FETCH_STALL_CNT_EN only) backpressure cycle count
// ---------------------------------------------------------------------------
module instr_fetch_ctrl
  import upower_fetch_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] END_PC   = 32'h0000_0014
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              busy,
  output logic              done
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int CRED_W = BUF_CNT_W + 1;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         epoch_q, epoch_d;
  logic         inflight_q, inflight_d;
  logic         inflight_epoch_q, inflight_epoch_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;

  logic                 start_take;
  logic                 redirect_take;
  logic                 pop;
  logic                 issue;
  logic                 resp_push;
  logic                 drain_empty;
  logic [CRED_W-1:0]    credit_used;
  logic [BUF_CNT_W-1:0] buf_count;
  logic                 buf_empty;
  fetch_entry_t         buf_head;
  fetch_entry_t         push_entry;

  assign start_take    = start && (state_q == IDLE);
  assign redirect_take = redirect_valid && (state_q != IDLE);
  assign pop           = !buf_empty && instr_ready;

  // Slots already claimed after this cycle's pop: buffered plus in flight.
  assign credit_used = CRED_W'(buf_count) + CRED_W'(inflight_q) - CRED_W'(pop);
  assign issue       = (state_q == FETCH) && !redirect_take &&
                       (credit_used < CRED_W'(FETCH_BUF_DEPTH));

  // A response tagged with an old epoch belongs to a flushed path.
  assign resp_push  = inflight_q && (inflight_epoch_q == epoch_q);
  assign push_entry = '{pc: inflight_pc_q, instr: mem_rdata};

  // Leave DRAIN on the edge that empties the buffer, so done rises in the
  // cycle right after the final handshake.
  assign drain_empty = !inflight_q &&
                       ((CRED_W'(buf_count) - CRED_W'(pop)) == '0);

  fetch_skid_fifo u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_take),
    .push      (resp_push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (buf_head),
    .count     (buf_count),
    .empty     (buf_empty)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (redirect_valid)               state_d = FETCH;
        else if (issue && pc_q == END_PC) state_d = DRAIN;
      end
      DRAIN: begin
        if (redirect_valid)   state_d = FETCH;
        else if (drain_empty) state_d = DONE;
      end
      DONE: begin
        if (redirect_valid) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_rd_en   = issue;
    mem_addr    = pc_q[ADDR_W+1:2];
    instr_valid = !buf_empty;
    instr       = '0;
    instr_pc    = '0;
    if (!buf_empty) begin
      instr    = buf_head.instr;
      instr_pc = buf_head.pc;
    end
    busy = (state_q == FETCH) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  // PC, epoch and in-flight tracking
  always_comb begin
    pc_d             = pc_q;
    epoch_d          = epoch_q;
    inflight_d       = issue;
    inflight_epoch_d = epoch_q;
    inflight_pc_d    = pc_q;
    if (start_take) begin
      pc_d = RESET_PC;
    end else if (redirect_take) begin
      pc_d    = align_word(redirect_pc);
      epoch_d = ~epoch_q;
    end else if (issue) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q             <= RESET_PC;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      epoch_q          <= epoch_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
    end
  end

  // PC of the outstanding read; only consumed when inflight_q is set
  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
  end

`ifdef FETCH_STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_take) begin
      stall_cnt_d = '0;
    end else if (instr_valid && !instr_ready) begin
      stall_cnt_d = sat_inc16(stall_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
